// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode character/attribute store.
package text_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [11:0] CELLS = 12'(COLS * ROWS);

  // Register word addresses on the Wishbone side.
  localparam logic [12:0] REG_CTRL = 13'h1000;
  localparam logic [12:0] REG_FILL = 13'h1001;
  localparam logic [12:0] REG_ID   = 13'h1002;

  // "TEXT" in ASCII.
  localparam logic [31:0] ID_VALUE = 32'h54455854;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/text_dpram.sv
// 4096x16 simple dual-port RAM with independent clocks.
// Port A: byte-lane writes plus read (one cycle latency).
// Port B: read-only, one cycle latency.
module text_dpram (
  input  logic        clk_a,
  input  logic [1:0]  we_a,
  input  logic [11:0] addr_a,
  input  logic [15:0] din_a,
  output logic [15:0] dout_a,
  input  logic        clk_b,
  input  logic [11:0] addr_b,
  output logic [15:0] dout_b
);

  logic [15:0] mem [0:4095];

  // Port A: lane writes and registered read-before-write.
  always_ff @(posedge clk_a) begin
    if (we_a[0]) mem[addr_a][7:0]  <= din_a[7:0];
    if (we_a[1]) mem[addr_a][15:8] <= din_a[15:8];
    dout_a <= mem[addr_a];
  end

  // Port B: registered read for the video side.
  always_ff @(posedge clk_b) begin
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/wb_text_ram.sv
// Character/attribute store for the 80x30 text renderer.
// Wishbone classic slave on I_clk (CPU), read-only video port on I_pix_clk,
// and a fill engine that writes one cell per cycle from the FILL register.
//
// Handshake: a request is taken when cyc & stb are high, no ack is being
// presented and no read is in flight; cell accesses additionally wait while
// the fill engine owns the RAM. Writes ack on the cycle after the request is
// taken, reads on the second cycle. O_wb_ack is a one-cycle pulse, O_wb_dat is
// zero whenever ack is low, and dropping cyc before a read ack cancels it.
module wb_text_ram
  import text_pkg::*;
#(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [15:0] FILL_RESET = 16'h0720
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_wb_cyc,
  input  logic        I_wb_stb,
  input  logic        I_wb_we,
  input  logic [12:0] I_wb_adr,
  input  logic [31:0] I_wb_dat,
  input  logic [3:0]  I_wb_sel,
  output logic [31:0] O_wb_dat,
  output logic        O_wb_ack,
  input  logic        I_pix_clk,
  input  logic [11:0] I_vid_addr,
  output logic [7:0]  O_vid_char,
  output logic [7:0]  O_vid_attr,
  output logic        O_busy
);

  localparam logic [11:0] NCELLS    = 12'(COLS * ROWS);
  localparam logic [11:0] LAST_CELL = NCELLS - 12'd1;

  fill_state_t state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] fill_q;
  logic [15:0] fill_lat_q;
  logic        busy;

  logic        is_cell;
  logic        req;
  logic        acc;
  logic        acc_wr;
  logic        acc_rd;
  logic        start;
  logic        rd_pend_q;
  logic        rd_cell_q;
  logic [31:0] rd_reg_q;
  logic [31:0] reg_rdata;

  logic [1:0]  we_a;
  logic [11:0] addr_a;
  logic [15:0] din_a;
  logic [15:0] q_a;
  logic [15:0] q_b;
  logic        vid_ok_q;

  // Upper data lanes and lanes 3:2 carry nothing in this map.
  logic        unused_bus;
  assign unused_bus = ^{I_wb_dat[31:16], I_wb_sel[3:2]};

  assign busy    = (state_q == ST_FILL);
  assign O_busy  = busy;
  assign is_cell = ~I_wb_adr[12] && (I_wb_adr[11:0] < NCELLS);
  assign req     = I_wb_cyc & I_wb_stb & ~O_wb_ack & ~rd_pend_q;
  assign acc     = req & ~(is_cell & busy);
  assign acc_wr  = acc & I_wb_we;
  assign acc_rd  = acc & ~I_wb_we;
  assign start   = acc_wr && (I_wb_adr == REG_CTRL) && I_wb_sel[0] && I_wb_dat[0];

  // Register read mux, captured when a read is taken.
  always_comb begin
    reg_rdata = 32'h0;
    case (I_wb_adr)
      REG_CTRL: reg_rdata = {31'h0, busy};
      REG_FILL: reg_rdata = {16'h0, fill_q};
      REG_ID:   reg_rdata = ID_VALUE;
      default:  reg_rdata = 32'h0;
    endcase
  end

  // Fill engine next state: walk every cell once, then return to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          cnt_d   = 12'd0;
        end
      end
      ST_FILL: begin
        if (cnt_q == LAST_CELL) begin
          state_d = ST_IDLE;
          cnt_d   = 12'd0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill engine state, counter, and the value snapshot used for this fill.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 12'd0;
      fill_lat_q <= FILL_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start && !busy) fill_lat_q <= fill_q;
    end
  end

  // RAM port A belongs to the fill engine while busy, otherwise to the bus.
  always_comb begin
    addr_a = I_wb_adr[11:0];
    din_a  = I_wb_dat[15:0];
    we_a   = 2'b00;
    if (busy) begin
      addr_a = cnt_q;
      din_a  = fill_lat_q;
      we_a   = 2'b11;
    end else if (acc_wr && is_cell) begin
      we_a = I_wb_sel[1:0];
    end
  end

  // Bus response pipeline and FILL register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_wb_ack  <= 1'b0;
      O_wb_dat  <= 32'h0;
      rd_pend_q <= 1'b0;
      rd_cell_q <= 1'b0;
      rd_reg_q  <= 32'h0;
      fill_q    <= FILL_RESET;
    end else begin
      rd_pend_q <= acc_rd;
      if (acc_rd) begin
        rd_cell_q <= is_cell;
        rd_reg_q  <= reg_rdata;
      end
      if (acc_wr) begin
        O_wb_ack <= 1'b1;
        O_wb_dat <= 32'h0;
      end else if (rd_pend_q && I_wb_cyc) begin
        O_wb_ack <= 1'b1;
        O_wb_dat <= rd_cell_q ? {16'h0, q_a} : rd_reg_q;
      end else begin
        O_wb_ack <= 1'b0;
        O_wb_dat <= 32'h0;
      end
      if (acc_wr && (I_wb_adr == REG_FILL)) begin
        if (I_wb_sel[0]) fill_q[7:0]  <= I_wb_dat[7:0];
        if (I_wb_sel[1]) fill_q[15:8] <= I_wb_dat[15:8];
      end
    end
  end

  // Video output register; cells past the screen read as zero.
  always_ff @(posedge I_pix_clk) begin
    vid_ok_q   <= (I_vid_addr < NCELLS);
    O_vid_char <= vid_ok_q ? q_b[7:0]  : 8'h00;
    O_vid_attr <= vid_ok_q ? q_b[15:8] : 8'h00;
  end

  text_dpram u_ram (
    .clk_a  (I_clk),
    .we_a   (we_a),
    .addr_a (addr_a),
    .din_a  (din_a),
    .dout_a (q_a),
    .clk_b  (I_pix_clk),
    .addr_b (I_vid_addr),
    .dout_b (q_b)
  );

endmodule

// File: tb/tb_wb_text_ram.sv
// Bench for wb_text_ram: directed scenarios plus randomized bus traffic,
// checked against a cell-array model through an expected-response queue.
module tb_wb_text_ram;

  localparam int          N_CELLS   = 2400;
  localparam logic [12:0] A_CTRL    = 13'h1000;
  localparam logic [12:0] A_FILL    = 13'h1001;
  localparam logic [12:0] A_ID      = 13'h1002;
  localparam logic [31:0] ID_WORD   = 32'h54455854;
  localparam logic [15:0] FILL_INIT = 16'h0720;

  logic        clk = 1'b0;
  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [12:0] wb_adr = 13'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic [11:0] vid_addr = 12'h0;
  logic [7:0]  vid_char;
  logic [7:0]  vid_attr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Expected responses: bit 32 marks a read whose data must be compared.
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  // Reference model of the visible state.
  logic [15:0] mdl_mem [0:4095];
  logic [15:0] mdl_fill = FILL_INIT;
  logic        mdl_busy = 1'b0;

  int  busy_run = 0;
  int  last_busy_run = 0;
  logic last_ack_busy = 1'b0;

  wb_text_ram dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_wb_cyc   (wb_cyc),
    .I_wb_stb   (wb_stb),
    .I_wb_we    (wb_we),
    .I_wb_adr   (wb_adr),
    .I_wb_dat   (wb_dat_i),
    .I_wb_sel   (wb_sel),
    .O_wb_dat   (wb_dat_o),
    .O_wb_ack   (wb_ack),
    .I_pix_clk  (pix_clk),
    .I_vid_addr (vid_addr),
    .O_vid_char (vid_char),
    .O_vid_attr (vid_attr),
    .O_busy     (busy)
  );

  // Clock and reset block.
  initial forever #5 clk = ~clk;
  initial forever #7 pix_clk = ~pix_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response; idle data must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with data %h, expected no ack", wb_dat_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[32]) check_eq("rd_data", wb_dat_o, mon_e[31:0]);
        end
      end else begin
        check_eq("dat_idle_zero", wb_dat_o, 32'h0);
      end
    end
  end

  // Length of each busy pulse in I_clk cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  function automatic logic [31:0] exp_read(input logic [12:0] adr);
    if (!adr[12]) begin
      if (int'(adr[11:0]) < N_CELLS) return {16'h0, mdl_mem[adr[11:0]]};
      return 32'h0;
    end
    if (adr == A_CTRL) return {31'h0, mdl_busy};
    if (adr == A_FILL) return {16'h0, mdl_fill};
    if (adr == A_ID) return ID_WORD;
    return 32'h0;
  endfunction

  task automatic mdl_write(input logic [12:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (!adr[12] && int'(adr[11:0]) < N_CELLS) begin
      if (sel[0]) mdl_mem[adr[11:0]][7:0] = dat[7:0];
      if (sel[1]) mdl_mem[adr[11:0]][15:8] = dat[15:8];
    end else if (adr == A_FILL) begin
      if (sel[0]) mdl_fill[7:0] = dat[7:0];
      if (sel[1]) mdl_fill[15:8] = dat[15:8];
    end
  endtask

  // Driver: one classic cycle, returns edges from request to ack.
  task automatic wb_xfer(input logic we, input logic [12:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat);
    @(posedge clk);
    #1;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we = we;
    wb_adr = adr;
    wb_dat_i = dat;
    wb_sel = sel;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!wb_ack && lat < 6000);
    last_ack_busy = busy;
    if (!wb_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: adr %h got no ack, expected ack", adr);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [12:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input int exp_lat);
    int lat;
    exp_q.push_back(33'h0);
    wb_xfer(1'b1, adr, dat, sel, lat);
    mdl_write(adr, dat, sel);
    if (exp_lat > 0) check_eq("wr_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic wb_read(input logic [12:0] adr, input logic [31:0] exp, input int exp_lat,
                         output int lat);
    exp_q.push_back({1'b1, exp});
    wb_xfer(1'b0, adr, 32'h0, 4'hF, lat);
    if (exp_lat > 0) check_eq("rd_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic start_fill(input logic [15:0] val);
    wb_write(A_FILL, {16'h0, val}, 4'hF, 1);
    wb_write(A_CTRL, 32'h1, 4'hF, 1);
    for (int c = 0; c < N_CELLS; c++) mdl_mem[c] = mdl_fill;
    mdl_busy = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("busy_cleared", {31'h0, busy}, 32'h0);
    mdl_busy = 1'b0;
    @(negedge clk);
    #1;
    check_eq("busy_len", 32'(last_busy_run), 32'd2400);
  endtask

  task automatic vid_check(input logic [11:0] addr, input logic [7:0] exp_c, input logic [7:0] exp_a);
    @(posedge pix_clk);
    #1;
    vid_addr = addr;
    @(posedge pix_clk);
    @(posedge pix_clk);
    #1;
    check_eq("vid_char", {24'h0, vid_char}, {24'h0, exp_c});
    check_eq("vid_attr", {24'h0, vid_attr}, {24'h0, exp_a});
  endtask

  initial begin
    int lat;
    int r;
    int ack_seen;
    logic [12:0] adr;
    logic [11:0] va;

    // Reset state.
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_ack", {31'h0, wb_ack}, 32'h0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    rst_n = 1'b1;
    wb_read(A_FILL, {16'h0, FILL_INIT}, 2, lat);
    wb_read(A_ID, ID_WORD, 2, lat);
    wb_read(A_CTRL, 32'h0, 2, lat);

    // Cell write/read with two lanes, then video view of the same cell.
    wb_write(13'd5, 32'h0000_1E41, 4'b0011, 1);
    wb_read(13'd5, 32'h0000_1E41, 2, lat);
    vid_check(12'd5, 8'h41, 8'h1E);

    // Single-lane write leaves the attribute untouched.
    wb_write(13'd7, 32'h0000_1E41, 4'b0011, 1);
    wb_write(13'd7, 32'h0000_FF58, 4'b0001, 1);
    wb_read(13'd7, 32'h0000_1E58, 2, lat);

    // Fill, with a cell read stalled until the engine finishes.
    start_fill(16'h1F20);
    check_eq("busy_after_start", {31'h0, busy}, 32'h1);
    wb_read(13'd1234, 32'h0000_1F20, 0, lat);
    check_eq("stall_busy_at_ack", {31'h0, last_ack_busy}, 32'h0);
    check_eq("stall_long", (lat > 2400) ? 32'h1 : 32'h0, 32'h1);
    wait_idle();
    wb_read(13'd0, exp_read(13'd0), 2, lat);
    wb_read(13'd2399, exp_read(13'd2399), 2, lat);
    vid_check(12'd1234, 8'h20, 8'h1F);
    vid_check(12'd2400, 8'h00, 8'h00);
    vid_check(12'd4095, 8'h00, 8'h00);

    // Registers stay live during a fill; restart and FILL write do not disturb it.
    start_fill(16'h4B2A);
    wb_read(A_CTRL, 32'h1, 2, lat);
    wb_read(A_ID, ID_WORD, 2, lat);
    wb_write(A_CTRL, 32'h1, 4'hF, 1);
    wb_write(A_FILL, 32'h0000_1111, 4'hF, 1);
    wait_idle();
    wb_read(A_FILL, 32'h0000_1111, 2, lat);
    wb_read(13'd100, 32'h0000_4B2A, 2, lat);
    wb_read(13'd2399, 32'h0000_4B2A, 2, lat);

    // Randomized traffic over cells, hole, registers and unmapped space.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2, 3, 4, 5: adr = 13'($urandom_range(0, N_CELLS - 1));
        6: adr = 13'($urandom_range(N_CELLS, 4095));
        7: adr = A_FILL;
        8: adr = A_ID;
        9: adr = A_CTRL;
        default: adr = 13'($urandom_range(32'h1003, 32'h1FFF));
      endcase
      if ($urandom_range(0, 1) == 1 && adr != A_CTRL)
        wb_write(adr, $urandom, 4'($urandom_range(0, 15)), 1);
      else
        wb_read(adr, exp_read(adr), 2, lat);
    end
    for (int i = 0; i < 8; i++) begin
      va = 12'($urandom_range(0, N_CELLS - 1));
      vid_check(va, mdl_mem[va][7:0], mdl_mem[va][15:8]);
    end

    // Hole reads zero; dropping cyc after a read is taken cancels its ack.
    wb_write(13'h0960, 32'hDEAD_BEEF, 4'hF, 1);
    wb_read(13'h0960, 32'h0, 2, lat);
    @(posedge clk);
    #1;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we = 1'b0;
    wb_adr = 13'd5;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    ack_seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (wb_ack) ack_seen++;
    end
    check_eq("cancel_no_ack", 32'(ack_seen), 32'h0);

    // Reset part-way through a fill.
    wb_write(13'd2000, 32'h0000_ABCD, 4'hF, 1);
    wb_write(A_FILL, 32'h0000_5C3D, 4'hF, 1);
    wb_write(A_CTRL, 32'h1, 4'hF, 1);
    repeat (1000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < 900; c++) mdl_mem[c] = 16'h5C3D;
    mdl_fill = FILL_INIT;
    mdl_busy = 1'b0;
    #2;
    check_eq("midrst_busy", {31'h0, busy}, 32'h0);
    check_eq("midrst_ack", {31'h0, wb_ack}, 32'h0);
    check_eq("midrst_dat", wb_dat_o, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("post_rst_busy", {31'h0, busy}, 32'h0);
    wb_read(A_FILL, {16'h0, FILL_INIT}, 2, lat);
    wb_read(A_CTRL, 32'h0, 2, lat);
    wb_read(13'd10, 32'h0000_5C3D, 2, lat);
    wb_read(13'd2000, 32'h0000_ABCD, 2, lat);

    repeat (4) @(posedge clk);
    #1;
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
